// File: rtl/synth_pkg.sv
// Shared types and constants for the audio synthesis path.
package synth_pkg;

    // Envelope generator phases, exported on env_state.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    // Full-scale envelope level.
    localparam logic [11:0] ENV_MAX   = 12'd4095;
    // Offset-binary midpoint: silence / 50% PWM duty.
    localparam logic [11:0] AUDIO_MID = 12'h800;

    // Scale an offset-binary sample about the midpoint by level/4096.
    // Floors toward -inf; the result always fits in 12 bits.
    function automatic logic [11:0] scale_sample(input logic [11:0] sample,
                                                 input logic [11:0] level);
        logic signed [12:0] diff;
        logic signed [24:0] prod;
        logic signed [24:0] shifted;
        diff    = $signed({1'b0, sample}) - 13'sd2048;
        prod    = diff * $signed({1'b0, level});
        shifted = prod >>> 12;
        return AUDIO_MID + shifted[11:0];
    endfunction

endpackage

// File: rtl/env_tick_divider.sv
// Free-running divider producing one envelope tick every TICK_DIV enabled clocks.
module env_tick_divider
    import synth_pkg::*;
#(
    parameter int TICK_DIV = 12000
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: wrap at TICK_DIV-1, hold while disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (ena) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick marks the last cycle of each divided period.
    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/audio_envelope_shaper.sv
// ADSR envelope applied to an offset-binary oscillator sample, centred on the
// midpoint so a closed envelope produces silence (50% PWM duty).
module audio_envelope_shaper
    import synth_pkg::*;
#(
    parameter int TICK_DIV = 12000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        gate,
    input  logic [11:0] sample_in,
    input  logic [7:0]  attack_step,
    input  logic [7:0]  decay_step,
    input  logic [11:0] sustain_level,
    input  logic [7:0]  release_step,
    output logic [11:0] audio_out,
    output logic [11:0] env_level,
    output logic [2:0]  env_state
);

    logic        tick;
    env_state_t  state_d;
    env_state_t  state_q;
    logic [11:0] level_d;
    logic [11:0] level_q;
    logic [11:0] audio_d;
    logic [11:0] audio_q;
    logic [12:0] add_s;
    logic [12:0] dec_s;
    logic [12:0] rel_s;

    env_tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .tick (tick)
    );

    // Candidate levels; bit 12 of dec_s/rel_s flags an underflow below zero.
    always_comb begin
        add_s = {1'b0, level_q} + {5'd0, attack_step};
        dec_s = {1'b0, level_q} - {5'd0, decay_step};
        rel_s = {1'b0, level_q} - {5'd0, release_step};
    end

    // Envelope FSM and level update; gate transitions take priority over ticks.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    level_d = 12'd0;
                    if (gate) begin
                        state_d = ST_ATTACK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ATTACK: begin
                    if (!gate) begin
                        state_d = ST_RELEASE;
                    end else if (tick) begin
                        if (add_s >= {1'b0, ENV_MAX}) begin
                            level_d = ENV_MAX;
                            state_d = ST_DECAY;
                        end else begin
                            level_d = add_s[11:0];
                        end
                    end else begin
                        level_d = level_q;
                    end
                end
                ST_DECAY: begin
                    if (!gate) begin
                        state_d = ST_RELEASE;
                    end else if (level_q <= sustain_level) begin
                        level_d = sustain_level;
                        state_d = ST_SUSTAIN;
                    end else if (tick) begin
                        if (dec_s[12] || (dec_s[11:0] <= sustain_level)) begin
                            level_d = sustain_level;
                            state_d = ST_SUSTAIN;
                        end else begin
                            level_d = dec_s[11:0];
                        end
                    end else begin
                        level_d = level_q;
                    end
                end
                ST_SUSTAIN: begin
                    if (!gate) begin
                        state_d = ST_RELEASE;
                    end else begin
                        level_d = sustain_level;
                    end
                end
                ST_RELEASE: begin
                    if (gate) begin
                        // Retrigger keeps the current level to avoid a click.
                        state_d = ST_ATTACK;
                    end else if (tick) begin
                        if (rel_s[12] || (rel_s[11:0] == 12'd0)) begin
                            level_d = 12'd0;
                            state_d = ST_IDLE;
                        end else begin
                            level_d = rel_s[11:0];
                        end
                    end else begin
                        level_d = level_q;
                    end
                end
                default: begin
                    level_d = 12'd0;
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
            level_d = level_q;
        end
    end

    // Output sample uses the registered level, one cycle after sample_in.
    always_comb begin
        if (ena) begin
            audio_d = scale_sample(sample_in, level_q);
        end else begin
            audio_d = audio_q;
        end
    end

    // State, level and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            level_q <= 12'd0;
            audio_q <= AUDIO_MID;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            audio_q <= audio_d;
        end
    end

    assign audio_out = audio_q;
    assign env_level = level_q;
    assign env_state = state_q;

endmodule

// File: tb/tb_audio_envelope_shaper.sv
// Directed scoreboard bench for audio_envelope_shaper with TICK_DIV = 4.
module tb_audio_envelope_shaper;
    import synth_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        gate;
    logic [11:0] sample_in;
    logic [7:0]  attack_step;
    logic [7:0]  decay_step;
    logic [11:0] sustain_level;
    logic [7:0]  release_step;
    logic [11:0] audio_out;
    logic [11:0] env_level;
    logic [2:0]  env_state;

    audio_envelope_shaper #(
        .TICK_DIV (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .gate          (gate),
        .sample_in     (sample_in),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .audio_out     (audio_out),
        .env_level     (env_level),
        .env_state     (env_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;    // 0 audio_out, 1 env_level, 2 env_state
        logic [11:0] exp;
    } exp_t;

    exp_t sb_q[$];
    event chk_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [11:0] actual(int sel);
        case (sel)
            0:       return audio_out;
            1:       return env_level;
            default: return {9'd0, env_state};
        endcase
    endfunction

    // Monitor: drain the scoreboard whenever the stimulus marks outputs valid.
    initial begin
        exp_t        e;
        logic [11:0] act;
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = actual(e.sel);
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%03h expected 0x%03h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic publish();
        -> chk_ev;
        #1;
    endtask

    task automatic expect_env(string nm, logic [11:0] lvl, logic [2:0] st);
        sb_q.push_back('{name: {nm, "_level"}, sel: 1, exp: lvl});
        sb_q.push_back('{name: {nm, "_state"}, sel: 2, exp: {9'd0, st}});
        publish();
    endtask

    task automatic expect_audio(string nm, logic [11:0] a);
        sb_q.push_back('{name: nm, sel: 0, exp: a});
        publish();
    endtask

    task automatic check_int(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance until env_level changes; a 16-cycle budget bounds the wait.
    task automatic wait_change(string nm, output int cyc);
        logic [11:0] old;
        old = env_level;
        cyc = 0;
        do begin
            step(1);
            cyc++;
        end while ((env_level == old) && (cyc < 16));
        if (env_level == old) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: level stuck at %0d for %0d cycles", nm, old, cyc);
        end
    endtask

    // Advance until env_state reaches target, bounded by budget cycles.
    task automatic wait_state(string nm, logic [2:0] target, int budget);
        int cyc;
        cyc = 0;
        while ((env_state != target) && (cyc < budget)) begin
            step(1);
            cyc++;
        end
        if (env_state != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: state %0d never reached %0d", nm, env_state, target);
        end
    endtask

    initial begin
        int cyc;
        rst           = 1'b1;
        ena           = 1'b1;
        gate          = 1'b0;
        sample_in     = 12'h800;
        attack_step   = 8'd255;
        decay_step    = 8'd100;
        sustain_level = 12'd2000;
        release_step  = 8'd250;

        // Reset asserted before any clock edge.
        #1;
        expect_audio("reset_audio", 12'h800);
        expect_env("reset", 12'd0, ST_IDLE);

        // Attack at full-scale positive sample.
        @(negedge clk);
        rst       = 1'b0;
        gate      = 1'b1;
        sample_in = 12'hFFF;
        step(1);
        expect_env("attack_entry", 12'd0, ST_ATTACK);
        for (int i = 1; i <= 17; i++) begin
            wait_change("attack_wait", cyc);
            if (i > 1) check_int("attack_tick_spacing", cyc, 4);
            if (i == 17) expect_env("attack_top", 12'd4095, ST_DECAY);
            else         expect_env("attack_step", 12'(255 * i), ST_ATTACK);
        end
        step(1);
        expect_audio("attack_full_scale", 12'hFFE);
        expect_env("decay_entry", 12'd4095, ST_DECAY);

        // Decay to sustain 2000 in steps of 100.
        for (int i = 1; i <= 21; i++) begin
            wait_change("decay_wait", cyc);
            if (i == 21) expect_env("decay_floor", 12'd2000, ST_SUSTAIN);
            else         expect_env("decay_step", 12'(4095 - 100 * i), ST_DECAY);
        end
        sustain_level = 12'd1500;
        step(1);
        expect_env("sustain_track", 12'd1500, ST_SUSTAIN);
        sustain_level = 12'd2000;
        step(1);
        expect_env("sustain_back", 12'd2000, ST_SUSTAIN);

        // Output arithmetic at level 2000, including flooring of small negatives.
        sample_in = 12'h400;
        step(1);
        expect_audio("scale_half_neg", 12'h60C);
        sample_in = 12'h801;
        step(1);
        expect_audio("scale_small_pos", 12'h800);
        sample_in = 12'h7FF;
        step(1);
        expect_audio("scale_floor_neg", 12'h7FF);

        // Release to zero in steps of 250.
        gate = 1'b0;
        step(1);
        expect_env("release_entry", 12'd2000, ST_RELEASE);
        for (int i = 1; i <= 8; i++) begin
            wait_change("release_wait", cyc);
            if (i == 8) expect_env("release_zero", 12'd0, ST_IDLE);
            else        expect_env("release_step", 12'(2000 - 250 * i), ST_RELEASE);
        end
        sample_in = 12'h123;
        step(1);
        expect_audio("closed_low", 12'h800);
        sample_in = 12'hFFF;
        step(1);
        expect_audio("closed_high", 12'h800);
        expect_env("idle_hold", 12'd0, ST_IDLE);

        // Climb to full scale; sustain at 4095 makes DECAY fall straight through.
        sustain_level = 12'd4095;
        gate          = 1'b1;
        wait_state("reach_sustain", ST_SUSTAIN, 200);
        expect_env("sustain_full", 12'd4095, ST_SUSTAIN);
        sample_in = 12'h000;
        step(1);
        expect_audio("full_scale_negative", 12'h000);
        sustain_level = 12'd2000;
        step(1);
        expect_env("sustain_drop", 12'd2000, ST_SUSTAIN);

        // Zero release step holds the level.
        release_step = 8'd0;
        gate         = 1'b0;
        step(1);
        expect_env("release_zero_step_entry", 12'd2000, ST_RELEASE);
        step(20);
        expect_env("release_zero_step_hold", 12'd2000, ST_RELEASE);

        // Retrigger at level 1000.
        release_step = 8'd250;
        for (int i = 1; i <= 4; i++) begin
            wait_change("retrig_release_wait", cyc);
            expect_env("retrig_release", 12'(2000 - 250 * i), ST_RELEASE);
        end
        gate = 1'b1;
        step(1);
        expect_env("retrig_entry", 12'd1000, ST_ATTACK);
        wait_change("retrig_wait1", cyc);
        check_int("retrig_tick_phase", cyc, 3);
        expect_env("retrig_step1", 12'd1255, ST_ATTACK);
        wait_change("retrig_wait2", cyc);
        expect_env("retrig_step2", 12'd1510, ST_ATTACK);

        // Gate drop in the tick cycle: transition wins, level not stepped.
        step(3);
        gate = 1'b0;
        step(1);
        expect_env("gate_on_tick", 12'd1510, ST_RELEASE);

        // Freeze mid-attack for 50 clocks.
        sample_in = 12'hFFF;
        gate      = 1'b1;
        step(1);
        expect_env("refire", 12'd1510, ST_ATTACK);
        wait_change("freeze_pre_wait", cyc);
        expect_env("freeze_pre", 12'd1765, ST_ATTACK);
        step(1);
        expect_audio("freeze_pre_audio", 12'hB72);
        ena       = 1'b0;
        sample_in = 12'h000;
        gate      = 1'b0;
        step(50);
        expect_audio("freeze_audio", 12'hB72);
        expect_env("freeze", 12'd1765, ST_ATTACK);
        gate      = 1'b1;
        sample_in = 12'hFFF;
        ena       = 1'b1;
        step(2);
        expect_env("resume_phase", 12'd1765, ST_ATTACK);
        step(1);
        expect_env("resume_tick", 12'd2020, ST_ATTACK);

        // Asynchronous reset mid-attack.
        rst = 1'b1;
        #1;
        expect_audio("abort_audio", 12'h800);
        expect_env("abort", 12'd0, ST_IDLE);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        expect_env("abort_restart", 12'd0, ST_ATTACK);

        publish();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
